rng_arbiter: RTL

- Owns a single 32-bit Fibonacci LFSR and shares it among N_REQ requesters using round-robin arbitration.
- Handles seeding, zero-state recovery and a post-seed warm-up period before any value is served.
- Each grant returns the current LFSR word and advances the LFSR exactly once, so no two requesters ever receive the same draw.
- Sits between the stochastic-test consumers and the RNG datapath.

---
 rtl/rng_pkg.sv | 34 +++
 rtl/rng_arbiter_rr.sv | 31 +++
 rtl/rng_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared types and LFSR step for the RNG arbiter.
// The step substitutes a default state so the register can never lock at zero.
package rng_pkg;

    localparam int LFSR_W = 32;
    localparam int TAP_A  = 31;
    localparam int TAP_B  = 21;
    localparam int TAP_C  = 1;
    localparam int TAP_D  = 0;

    typedef enum logic [1:0] {
        LOAD,
        WARMUP,
        SERVE
    } rng_state_e;

    function automatic logic [LFSR_W-1:0] zero_sub(
        input logic [LFSR_W-1:0] v,
        input logic [LFSR_W-1:0] dflt
    );
        return (v == '0) ? dflt : v;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] r,
        input logic [LFSR_W-1:0] dflt
    );
        logic fb;
        if (r == '0) return dflt;
        fb = r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
        return {fb, r[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/rng_arbiter_rr.sv
// Combinational round-robin picker: search starts at ptr and wraps upward.
// Produces a one-hot grant plus the encoded index of the winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Shared 32-bit LFSR served round-robin to N_REQ requesters.
// Reseed goes LOAD -> WARMUP -> SERVE; each grant consumes exactly one step.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int          N_REQ         = 4,
    parameter int          WARMUP_CYCLES = 8,
    parameter logic [31:0] DEFAULT_SEED  = 32'hAAAA_AAAA
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [31:0]      rnd_data,
    input  logic [31:0]      seed,
    input  logic             seed_load,
    output logic             busy,
    output logic [15:0]      draw_cnt
);

    localparam int         IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] WCNT_INIT = 8'(WARMUP_CYCLES);

    rng_state_e        state_q;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_d;
    logic [31:0]       seed_q;
    logic [7:0]        wcnt_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     rr_ptr_d;
    logic [15:0]       draw_q;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              serve;
    logic              grant;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // A reseed strobe wins over any pending request in the same cycle.
    assign serve    = (state_q == SERVE) && !seed_load;
    assign gnt      = serve ? arb_gnt : '0;
    assign grant    = |gnt;
    assign busy     = (state_q != SERVE);
    assign rnd_data = lfsr_q;
    assign draw_cnt = draw_q;
    assign lfsr_d   = lfsr_next(lfsr_q, DEFAULT_SEED);
    assign rr_ptr_d = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WARMUP;
            lfsr_q   <= DEFAULT_SEED;
            seed_q   <= DEFAULT_SEED;
            wcnt_q   <= WCNT_INIT;
            rr_ptr_q <= '0;
            draw_q   <= '0;
        end else if (seed_load) begin
            state_q <= LOAD;
            seed_q  <= seed;
        end else begin
            unique case (state_q)
                LOAD: begin
                    lfsr_q  <= zero_sub(seed_q, DEFAULT_SEED);
                    wcnt_q  <= WCNT_INIT;
                    state_q <= WARMUP;
                end
                WARMUP: begin
                    if (wcnt_q == 8'd0) begin
                        state_q <= SERVE;
                    end else begin
                        lfsr_q <= lfsr_d;
                        wcnt_q <= wcnt_q - 8'd1;
                    end
                end
                SERVE: begin
                    if (grant) begin
                        lfsr_q   <= lfsr_d;
                        draw_q   <= draw_q + 16'd1;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q <= WARMUP;
                    wcnt_q  <= WCNT_INIT;
                end
            endcase
        end
    end

endmodule
